// File: rtl/inv_ntt_gs_butterfly.sv
// ---------------------------------------------------------------------------
// inv_ntt_gs_butterfly
//
// Pipelined Gentleman-Sande butterfly for the Kyber inverse NTT.
//   a_o = (a + b) mod Q
//   b_o = zeta * (b - a) mod Q
// One butterfly per cycle, valid/ready on both sides, global stall.
//
// Pipeline:
//   stage 1 : modular sum and difference, zeta captured
//   stage 2 : difference * zeta (full 2*WIDTH product)
//   stage 3 : Barrett reduction of the product -> a_o/b_o (latency 3)
//   stage 4 : only with INV_NTT_SCALE_EN, optional multiply of both results
//             by F = 128^-1 mod Q on beats flagged with scale_i (latency 4)
//
// Build option: define INV_NTT_SCALE_EN to add the scale_i port and stage 4.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low; drops all in-flight beats
//   in_valid   a_i/b_i/zeta_i (and scale_i) valid
//   in_ready   butterfly accepts input this cycle (0 while in reset)
//   a_i        upper-half coefficient a, in [0,Q)
//   b_i        lower-half coefficient b, in [0,Q)
//   zeta_i     twiddle factor for this pair, in [0,Q)
//   scale_i    (INV_NTT_SCALE_EN only) final-layer scale flag for this beat
//   out_valid  a_o/b_o valid
//   out_ready  downstream accepts output
//   a_o        (a+b) mod Q
//   b_o        zeta*(b-a) mod Q
// ---------------------------------------------------------------------------
module inv_ntt_gs_butterfly #(
    parameter int Q     = 3329,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] zeta_i,
`ifdef INV_NTT_SCALE_EN
    input  logic             scale_i,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    localparam logic [WIDTH-1:0]   Q_W  = WIDTH'(Q);
    localparam logic [WIDTH:0]     Q_S  = (WIDTH+1)'(Q);
    localparam logic [2*WIDTH-1:0] Q_2W = (2*WIDTH)'(Q);
    // m = floor(2^(2*WIDTH) / Q). Since every reduced value p < 2^(2*WIDTH),
    // the quotient estimate is low by at most one, so one conditional
    // subtract makes the result exact.
    localparam logic [2*WIDTH-1:0] BARRETT_M = (2*WIDTH)'((64'd1 << (2*WIDTH)) / Q);

    // Constant-Q Barrett reduction, exact for all p < 2^(2*WIDTH).
    function automatic logic [WIDTH-1:0] mod_q(input logic [2*WIDTH-1:0] p);
        logic [4*WIDTH-1:0] prod;
        logic [2*WIDTH-1:0] quo;
        logic [2*WIDTH-1:0] rem;
        prod = {{(2*WIDTH){1'b0}}, p} * {{(2*WIDTH){1'b0}}, BARRETT_M};
        quo  = (2*WIDTH)'(prod >> (2*WIDTH));
        rem  = p - quo * Q_2W;
        // rem < 2Q here, so the low WIDTH bits of rem - Q are exact.
        return (rem >= Q_2W) ? (rem[WIDTH-1:0] - Q_W) : rem[WIDTH-1:0];
    endfunction

    // Global stall: every stage moves only when the output slot is free.
    logic adv;
    logic out_valid_reg;
    logic [WIDTH-1:0] a_out_reg;
    logic [WIDTH-1:0] b_out_reg;

    assign adv       = !out_valid_reg || out_ready;
    assign in_ready  = rst_n && adv;
    assign out_valid = out_valid_reg;
    assign a_o       = a_out_reg;
    assign b_o       = b_out_reg;

    // ---------------- stage 1: modular add / subtract ----------------
    logic [WIDTH:0]   sum_wide;
    logic [WIDTH:0]   diff_wide;
    logic [WIDTH-1:0] s1_next;
    logic [WIDTH-1:0] d1_next;

    always_comb begin
        sum_wide  = {1'b0, a_i} + {1'b0, b_i};
        // b - a as a (WIDTH+1)-bit two's-complement value; the MSB is the sign.
        diff_wide = {1'b0, b_i} - {1'b0, a_i};
        s1_next   = (sum_wide >= Q_S) ? (sum_wide[WIDTH-1:0] - Q_W) : sum_wide[WIDTH-1:0];
        d1_next   = diff_wide[WIDTH] ? (diff_wide[WIDTH-1:0] + Q_W) : diff_wide[WIDTH-1:0];
    end

    logic             v1_reg;
    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] d1_reg;
    logic [WIDTH-1:0] z1_reg;
`ifdef INV_NTT_SCALE_EN
    logic             sc1_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_reg  <= 1'b0;
            s1_reg  <= '0;
            d1_reg  <= '0;
            z1_reg  <= '0;
`ifdef INV_NTT_SCALE_EN
            sc1_reg <= 1'b0;
`endif
        end else if (adv) begin
            v1_reg <= in_valid;
            if (in_valid) begin
                s1_reg  <= s1_next;
                d1_reg  <= d1_next;
                z1_reg  <= zeta_i;
`ifdef INV_NTT_SCALE_EN
                sc1_reg <= scale_i;
`endif
            end
        end
    end

    // ---------------- stage 2: twiddle multiply ----------------
    logic [2*WIDTH-1:0] p2_next;
    assign p2_next = {{WIDTH{1'b0}}, d1_reg} * {{WIDTH{1'b0}}, z1_reg};

    logic               v2_reg;
    logic [WIDTH-1:0]   s2_reg;
    logic [2*WIDTH-1:0] p2_reg;
`ifdef INV_NTT_SCALE_EN
    logic               sc2_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_reg  <= 1'b0;
            s2_reg  <= '0;
            p2_reg  <= '0;
`ifdef INV_NTT_SCALE_EN
            sc2_reg <= 1'b0;
`endif
        end else if (adv) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                s2_reg  <= s1_reg;
                p2_reg  <= p2_next;
`ifdef INV_NTT_SCALE_EN
                sc2_reg <= sc1_reg;
`endif
            end
        end
    end

    // ---------------- stage 3: Barrett reduction ----------------
    logic [WIDTH-1:0] r3_next;
    assign r3_next = mod_q(p2_reg);

`ifdef INV_NTT_SCALE_EN
    localparam logic [WIDTH-1:0] F_W = WIDTH'(3303);   // 128^-1 mod 3329

    logic             v3_reg;
    logic [WIDTH-1:0] s3_reg;
    logic [WIDTH-1:0] r3_reg;
    logic             sc3_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3_reg  <= 1'b0;
            s3_reg  <= '0;
            r3_reg  <= '0;
            sc3_reg <= 1'b0;
        end else if (adv) begin
            v3_reg <= v2_reg;
            if (v2_reg) begin
                s3_reg  <= s2_reg;
                r3_reg  <= r3_next;
                sc3_reg <= sc2_reg;
            end
        end
    end

    // ---------------- stage 4: optional final-layer scaling ----------------
    logic [WIDTH-1:0] a4_next;
    logic [WIDTH-1:0] b4_next;

    always_comb begin
        a4_next = s3_reg;
        b4_next = r3_reg;
        if (sc3_reg) begin
            a4_next = mod_q({{WIDTH{1'b0}}, s3_reg} * {{WIDTH{1'b0}}, F_W});
            b4_next = mod_q({{WIDTH{1'b0}}, r3_reg} * {{WIDTH{1'b0}}, F_W});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            a_out_reg     <= '0;
            b_out_reg     <= '0;
        end else if (adv) begin
            out_valid_reg <= v3_reg;
            if (v3_reg) begin
                a_out_reg <= a4_next;
                b_out_reg <= b4_next;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            a_out_reg     <= '0;
            b_out_reg     <= '0;
        end else if (adv) begin
            out_valid_reg <= v2_reg;
            if (v2_reg) begin
                a_out_reg <= s2_reg;
                b_out_reg <= r3_next;
            end
        end
    end
`endif

endmodule
